// File: rtl/intersection_scheduler_pkg.sv
// Shared lamp encodings, phase codes and direction constants for the
// intersection scheduler and its testbench.
package intersection_scheduler_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b100;

  localparam logic [2:0] PH_ALLRED = 3'd0;
  localparam logic [2:0] PH_NS_G   = 3'd1;
  localparam logic [2:0] PH_NS_Y   = 3'd2;
  localparam logic [2:0] PH_EW_G   = 3'd3;
  localparam logic [2:0] PH_EW_Y   = 3'd4;
  localparam logic [2:0] PH_WALK   = 3'd5;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Returns {ns_light, ew_light}; any non-phase code shows both red.
  function automatic logic [5:0] lamp_decode(input logic [2:0] ph);
    logic [5:0] lamps;
    case (ph)
      PH_NS_G: lamps = {LAMP_GREEN, LAMP_RED};
      PH_NS_Y: lamps = {LAMP_YELLOW, LAMP_RED};
      PH_EW_G: lamps = {LAMP_RED, LAMP_GREEN};
      PH_EW_Y: lamps = {LAMP_RED, LAMP_YELLOW};
      default: lamps = {LAMP_RED, LAMP_RED};
    endcase
    return lamps;
  endfunction

  // A phase of N cycles loads N-1; 256 therefore fits the 8-bit timer as 255.
  function automatic logic [7:0] load_of(input int cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Pedestrian request and lamp/phase outputs of the intersection scheduler.
interface intersection_scheduler_if;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  modport master (
    input  ped_req,
    output ns_light, ew_light, walk, phase
  );

  modport slave (
    output ped_req,
    input  ns_light, ew_light, walk, phase
  );
endinterface

// File: rtl/intersection_scheduler_phase_timer.sv
// 8-bit phase down-counter: loads length-1 on phase entry, flags zero.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 8'd0);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way traffic light phase sequencer with coalesced pedestrian walk
// service; all outputs are decoded from registered state only.
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  intersection_scheduler_if.master  bus
);

  localparam logic [7:0] GREEN_LD  = load_of(GREEN_CYC);
  localparam logic [7:0] YELLOW_LD = load_of(YELLOW_CYC);
  localparam logic [7:0] ALLRED_LD = load_of(ALLRED_CYC);
  localparam logic [7:0] WALK_LD   = load_of(WALK_CYC);

  logic [2:0] phase_q, phase_d;
  logic       next_dir_q, next_dir_d;
  logic       ped_pending_q, ped_pending_d;
  logic       timer_load;
  logic [7:0] timer_load_val;
  logic       timer_expired;

  phase_timer #(
    .RST_VAL (ALLRED_LD)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .expired  (timer_expired)
  );

  always_comb begin
    phase_d        = phase_q;
    next_dir_d     = next_dir_q;
    timer_load     = 1'b0;
    timer_load_val = ALLRED_LD;
    case (phase_q)
      PH_ALLRED: if (timer_expired) begin
        timer_load = 1'b1;
        if (ped_pending_q) begin
          phase_d        = PH_WALK;
          timer_load_val = WALK_LD;
        end else begin
          phase_d        = (next_dir_q == DIR_NS) ? PH_NS_G : PH_EW_G;
          timer_load_val = GREEN_LD;
        end
      end
      PH_NS_G: if (timer_expired) begin
        timer_load     = 1'b1;
        phase_d        = PH_NS_Y;
        timer_load_val = YELLOW_LD;
      end
      PH_NS_Y: if (timer_expired) begin
        timer_load = 1'b1;
        phase_d    = PH_ALLRED;
        next_dir_d = DIR_EW;
      end
      PH_EW_G: if (timer_expired) begin
        timer_load     = 1'b1;
        phase_d        = PH_EW_Y;
        timer_load_val = YELLOW_LD;
      end
      PH_EW_Y: if (timer_expired) begin
        timer_load = 1'b1;
        phase_d    = PH_ALLRED;
        next_dir_d = DIR_NS;
      end
      PH_WALK: if (timer_expired) begin
        timer_load     = 1'b1;
        phase_d        = (next_dir_q == DIR_NS) ? PH_NS_G : PH_EW_G;
        timer_load_val = GREEN_LD;
      end
      default: begin
        // Corrupted state: restart a clean clearance toward north-south.
        timer_load = 1'b1;
        phase_d    = PH_ALLRED;
        next_dir_d = DIR_NS;
      end
    endcase
  end

  // Requests seen during WALK or on its entry edge are dropped, not queued.
  always_comb begin
    ped_pending_d = ped_pending_q | bus.ped_req;
    if (phase_d == PH_WALK && phase_q != PH_WALK) begin
      ped_pending_d = 1'b0;
    end else if (phase_q == PH_WALK) begin
      ped_pending_d = ped_pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= PH_ALLRED;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign {bus.ns_light, bus.ew_light} = lamp_decode(phase_q);
  assign bus.walk  = (phase_q == PH_WALK);
  assign bus.phase = phase_q;

endmodule
